freq_event_counter: RTL and testbench
=====================================

Name: freq_event_counter

Overview:
- Receive-side companion to the free-running output counter: counts rising edges on an external asynchronous input over a programmable gate window of clk cycles.
- Publishes the edge count as a measurement result, so a counter or clock-divider output from another tile or pin can be read back and checked.
- Sits behind the tile's dedicated inputs; the result is multiplexed to the dedicated outputs by the top level.

Parameters:
CNT_W, 16, width of the edge counter and of result
GATE_W, 16, width of gate_len and of the internal gate down-counter
SYNC_STAGES, 2, number of synchroniser flops on event_in (minimum 2)

Ports:
clk  input  1  clock
rst  input  1  asynchronous reset, active high
ena  input  1  tile enable; when low, the gate and edge counting are frozen
event_in  input  1  asynchronous event signal; rising edges are counted
start  input  1  pulse; latches gate_len and opens a measurement window
abort  input  1  pulse; cancels the measurement in progress
gate_len  input  GATE_W  window length in enabled clk cycles
result  output  CNT_W  last completed edge count
result_valid  output  1  one-cycle pulse when result updates
busy  output  1  high while in the COUNT or DONE state
ovf  output  1  counter overflowed during the last completed window

Behaviour:
- Reset (async, rst=1):
  - Synchroniser flops, previous-sample flop, edge counter, gate counter, result, result_valid, busy and ovf all clear to 0.
  - State goes to IDLE.
  - Reset mid-window discards the measurement; no result_valid is produced.
- Input path:
  - event_in passes through SYNC_STAGES flops, then one previous-sample flop.
  - edge = sync & ~prev. Latency from event_in to edge is SYNC_STAGES+1 cycles.
  - The edge detector runs in every state, regardless of ena, so no false edge appears at window start.
- State machine: IDLE, COUNT, DONE.
  - IDLE, start=1, gate_len!=0, abort=0: load gate counter with gate_len, clear edge counter and ovf_run, go to COUNT. busy=1 from the next cycle.
  - IDLE, start=1, gate_len=0: start is ignored and the state stays IDLE.
  - COUNT, ena=1: the gate counter decrements. If edge=1, the edge counter increments.
  - When the gate counter is 1 and ena=1, that cycle's edge is still counted, then the state goes to DONE. The window is exactly gate_len enabled cycles.
  - COUNT, ena=0: the gate and edge counters hold. Edges seen while ena=0 are lost.
  - COUNT, start=1: ignored (no restart).
  - COUNT, abort=1: go to IDLE. result, ovf and result_valid are unchanged.
  - start and abort in the same cycle: abort wins.
  - DONE (one cycle): result <= edge counter, ovf <= ovf_run, result_valid=1 for this cycle only, then IDLE. abort in DONE is ignored.
- Arithmetic:
  - The edge counter wraps modulo 2^CNT_W. An increment from all-ones sets ovf_run, which is sticky for the window.
  - result and ovf hold their values until the next DONE.

Optional Feature:
- Macro: FREQ_CNT_SAT_EN.
- Defined: the edge counter saturates at 2^CNT_W-1 instead of wrapping. ovf_run is still set on the first increment attempted at all-ones.
- Undefined: the edge counter wraps as described in Behaviour.

Test Plan:
- Reset values: assert rst mid-simulation. result=0, result_valid=0, busy=0, ovf=0 immediately, with no clock edge needed.
- Basic window: event_in is a clk-synchronous pulse train, high 1 cycle in every 4, running long before start. gate_len=20, ena=1. Expect one result_valid pulse, result=5, ovf=0, and busy high for 21 cycles.
- Overflow: CNT_W=4, event_in toggles every cycle (period 2), gate_len=40.
  - Macro undefined: result=4, ovf=1.
  - FREQ_CNT_SAT_EN defined: result=15, ovf=1.
- ena freeze: same stimulus as the basic window, gate_len=20, with ena low for 8 cycles mid-window. busy is high for 29 cycles and result_valid arrives 8 cycles later than in the basic window.
- Abort, ignore and reset:
  - abort 5 cycles into a window: no result_valid, result keeps its prior value, busy=0 on the next cycle.
  - start with gate_len=0: busy stays 0.
  - start+abort in the same IDLE cycle: no window opens.
  - rst asserted mid-COUNT: all outputs 0 and no result_valid.

Source files
------------

// File: rtl/freq_event_counter_if.sv
// Control/result bundle for freq_event_counter: window request in, measurement out.
// result_valid is a one-cycle pulse with no ready; result and ovf hold until the next pulse.
interface freq_event_counter_if #(
    parameter int CNT_W  = 16,
    parameter int GATE_W = 16
);
    logic              start;
    logic              abort;
    logic [GATE_W-1:0] gate_len;
    logic [CNT_W-1:0]  result;
    logic              result_valid;
    logic              busy;
    logic              ovf;

    modport master (
        output start, abort, gate_len,
        input  result, result_valid, busy, ovf
    );

    modport slave (
        input  start, abort, gate_len,
        output result, result_valid, busy, ovf
    );
endinterface

// File: rtl/freq_event_counter.sv
// Counts rising edges of an asynchronous input over a gate of gate_len enabled clk cycles.
// Build option FREQ_CNT_SAT_EN: edge counter saturates at all-ones instead of wrapping.
module freq_event_counter #(
    parameter int CNT_W       = 16,
    parameter int GATE_W      = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ena,
    input  logic                 event_in,
    freq_event_counter_if.slave  bus,
    output logic [1:0]           state_dbg
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic                   edge_det;
    logic [CNT_W-1:0]       edge_cnt;
    logic [CNT_W-1:0]       cnt_inc;
    logic                   ovf_run;
    logic                   ovf_inc;
    logic [GATE_W-1:0]      gate_cnt;
    logic [CNT_W-1:0]       result_q;
    logic                   result_valid_q;
    logic                   busy_q;
    logic                   ovf_q;

    // Edge detector runs in every state so a level already high at window start is not counted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], event_in};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign edge_det = sync_q[SYNC_STAGES-1] & ~prev_q;

    always_comb begin
        cnt_inc = edge_cnt;
        ovf_inc = ovf_run;
        if (edge_det) begin
            if (&edge_cnt) begin
                ovf_inc = 1'b1;
`ifdef FREQ_CNT_SAT_EN
                cnt_inc = edge_cnt;
`else
                cnt_inc = '0;
`endif
            end else begin
                cnt_inc = edge_cnt + CNT_W'(1);
            end
        end
    end

    // Result is loaded on the last COUNT cycle so it is already valid during the DONE cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            edge_cnt       <= '0;
            ovf_run        <= 1'b0;
            gate_cnt       <= '0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
            busy_q         <= 1'b0;
            ovf_q          <= 1'b0;
        end else begin
            result_valid_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start && !bus.abort && (bus.gate_len != '0)) begin
                        gate_cnt <= bus.gate_len;
                        edge_cnt <= '0;
                        ovf_run  <= 1'b0;
                        busy_q   <= 1'b1;
                        state    <= COUNT;
                    end
                end
                COUNT: begin
                    if (bus.abort) begin
                        busy_q <= 1'b0;
                        state  <= IDLE;
                    end else if (ena) begin
                        edge_cnt <= cnt_inc;
                        ovf_run  <= ovf_inc;
                        gate_cnt <= gate_cnt - GATE_W'(1);
                        if (gate_cnt == GATE_W'(1)) begin
                            result_q       <= cnt_inc;
                            ovf_q          <= ovf_inc;
                            result_valid_q <= 1'b1;
                            state          <= DONE;
                        end
                    end
                end
                DONE: begin
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    assign bus.result       = result_q;
    assign bus.result_valid = result_valid_q;
    assign bus.busy         = busy_q;
    assign bus.ovf          = ovf_q;
    assign state_dbg        = state;
endmodule

// File: tb/tb_freq_event_counter.sv
// Directed bench for freq_event_counter: a 16-bit instance on a 1-in-4 pulse train
// and a 4-bit instance on a toggling input, checked through expected-result queues.
module tb_freq_event_counter;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic ena = 1'b1;
    logic event_a = 1'b0;
    logic event_b = 1'b0;
    logic [1:0] ev_ph = 2'd0;
    logic [1:0] state_a;
    logic [1:0] state_b;
    int cyc = 0;
    int start_cyc_a = 0;
    int start_cyc_b = 0;
    int vec_cnt = 0;
    int err_cnt = 0;
    int busy_run_a = 0;
    int busy_run_b = 0;

    // Entry: {latency from start[7:0], ovf, result[15:0]}
    logic [24:0] exp_a_q[$];
    logic [24:0] exp_b_q[$];
    int busy_a_q[$];
    int busy_b_q[$];
    logic [24:0] ea;
    logic [24:0] eb;

`ifdef FREQ_CNT_SAT_EN
    localparam logic [15:0] EXP_B_RES = 16'd15;
`else
    localparam logic [15:0] EXP_B_RES = 16'd4;
`endif

    freq_event_counter_if #(.CNT_W(16), .GATE_W(16)) ifa ();
    freq_event_counter_if #(.CNT_W(4),  .GATE_W(16)) ifb ();

    freq_event_counter #(.CNT_W(16), .GATE_W(16), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst), .ena(ena), .event_in(event_a), .bus(ifa), .state_dbg(state_a)
    );

    freq_event_counter #(.CNT_W(4), .GATE_W(16), .SYNC_STAGES(2)) dut4 (
        .clk(clk), .rst(rst), .ena(ena), .event_in(event_b), .bus(ifb), .state_dbg(state_b)
    );

    // ---------------- clock / reset / free-running stimulus ----------------
    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc     <= cyc + 1;
        ev_ph   <= ev_ph + 2'd1;
        event_a <= (ev_ph == 2'd0);
        event_b <= ~event_b;
    end

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_a(input int lat, input logic ovf, input logic [15:0] res, input int busy_len);
        exp_a_q.push_back({8'(lat), ovf, res});
        busy_a_q.push_back(busy_len);
    endtask

    task automatic push_b(input int lat, input logic ovf, input logic [15:0] res, input int busy_len);
        exp_b_q.push_back({8'(lat), ovf, res});
        busy_b_q.push_back(busy_len);
    endtask

    // ---------------- driver tasks ----------------
    task automatic start_a(input logic [15:0] len);
        ifa.start    = 1'b1;
        ifa.gate_len = len;
        @(posedge clk);
        #1;
        start_cyc_a  = cyc;
        ifa.start    = 1'b0;
    endtask

    task automatic start_b(input logic [15:0] len);
        ifb.start    = 1'b1;
        ifb.gate_len = len;
        @(posedge clk);
        #1;
        start_cyc_b  = cyc;
        ifb.start    = 1'b0;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // ---------------- scoreboard monitors ----------------
    always @(negedge clk) begin
        if (!rst && ifa.result_valid) begin
            if (exp_a_q.size() == 0) begin
                vec_cnt++;
                err_cnt++;
                $display("FAIL rv_a_unexpected: got result_valid=1 result=%0d expected no pulse", ifa.result);
            end else begin
                ea = exp_a_q.pop_front();
                check("lat_a", cyc - start_cyc_a, {24'd0, ea[24:17]});
                check("ovf_a", {31'd0, ifa.ovf}, {31'd0, ea[16]});
                check("res_a", {16'd0, ifa.result}, {16'd0, ea[15:0]});
            end
        end
        if (rst) begin
            busy_run_a = 0;
        end else if (ifa.busy) begin
            busy_run_a++;
        end else if (busy_run_a != 0) begin
            if (busy_a_q.size() == 0) begin
                vec_cnt++;
                err_cnt++;
                $display("FAIL busy_a_unexpected: got busy run %0d expected none", busy_run_a);
            end else begin
                check("busy_len_a", busy_run_a, busy_a_q.pop_front());
            end
            busy_run_a = 0;
        end
    end

    always @(negedge clk) begin
        if (!rst && ifb.result_valid) begin
            if (exp_b_q.size() == 0) begin
                vec_cnt++;
                err_cnt++;
                $display("FAIL rv_b_unexpected: got result_valid=1 result=%0d expected no pulse", ifb.result);
            end else begin
                eb = exp_b_q.pop_front();
                check("lat_b", cyc - start_cyc_b, {24'd0, eb[24:17]});
                check("ovf_b", {31'd0, ifb.ovf}, {31'd0, eb[16]});
                check("res_b", {28'd0, ifb.result}, {16'd0, eb[15:0]});
            end
        end
        if (rst) begin
            busy_run_b = 0;
        end else if (ifb.busy) begin
            busy_run_b++;
        end else if (busy_run_b != 0) begin
            if (busy_b_q.size() == 0) begin
                vec_cnt++;
                err_cnt++;
                $display("FAIL busy_b_unexpected: got busy run %0d expected none", busy_run_b);
            end else begin
                check("busy_len_b", busy_run_b, busy_b_q.pop_front());
            end
            busy_run_b = 0;
        end
    end

    // ---------------- directed sequence ----------------
    initial begin
        ifa.start = 1'b0; ifa.abort = 1'b0; ifa.gate_len = '0;
        ifb.start = 1'b0; ifb.abort = 1'b0; ifb.gate_len = '0;

        #1 rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("rst0_result_a", {16'd0, ifa.result}, 32'd0);
        check("rst0_rv_a",     {31'd0, ifa.result_valid}, 32'd0);
        check("rst0_busy_a",   {31'd0, ifa.busy}, 32'd0);
        check("rst0_ovf_a",    {31'd0, ifa.ovf}, 32'd0);
        check("rst0_state_a",  {30'd0, state_a}, 32'd0);
        check("rst0_result_b", {28'd0, ifb.result}, 32'd0);
        check("rst0_busy_b",   {31'd0, ifb.busy}, 32'd0);
        check("rst0_ovf_b",    {31'd0, ifb.ovf}, 32'd0);
        wait_cycles(1);
        rst = 1'b0;
        wait_cycles(10);

        // Basic window: 20 cycles of a period-4 train -> 5 edges
        push_a(20, 1'b0, 16'd5, 21);
        start_a(16'd20);
        wait_cycles(30);

        // ena low for 8 cycles mid-window: window stretches by 8, count unchanged
        push_a(28, 1'b0, 16'd5, 29);
        start_a(16'd20);
        wait_cycles(6);
        ena = 1'b0;
        wait_cycles(8);
        ena = 1'b1;
        wait_cycles(30);

        // Overflow on the 4-bit instance: 20 edges in 40 cycles
        push_b(40, 1'b1, EXP_B_RES, 41);
        start_b(16'd40);
        wait_cycles(50);

        // Abort 5 cycles into a window: no result, prior result kept
        busy_a_q.push_back(5);
        start_a(16'd20);
        wait_cycles(4);
        ifa.abort = 1'b1;
        wait_cycles(1);
        ifa.abort = 1'b0;
        @(negedge clk);
        check("abort_state_a", {30'd0, state_a}, 32'd0);
        check("abort_keep_res_a", {16'd0, ifa.result}, 32'd5);
        check("abort_keep_ovf_a", {31'd0, ifa.ovf}, 32'd0);
        wait_cycles(10);

        // gate_len = 0 is ignored
        start_a(16'd0);
        @(negedge clk);
        check("gate0_busy_a", {31'd0, ifa.busy}, 32'd0);
        check("gate0_state_a", {30'd0, state_a}, 32'd0);
        wait_cycles(5);

        // start and abort together: abort wins
        ifa.start = 1'b1; ifa.abort = 1'b1; ifa.gate_len = 16'd10;
        wait_cycles(1);
        ifa.start = 1'b0; ifa.abort = 1'b0;
        @(negedge clk);
        check("start_abort_busy_a", {31'd0, ifa.busy}, 32'd0);
        wait_cycles(15);

        // Reset mid-COUNT: outputs clear without a clock edge, no result produced
        start_a(16'd30);
        wait_cycles(10);
        check("pre_rst_busy_a", {31'd0, ifa.busy}, 32'd1);
        rst = 1'b1;
        #1;
        check("rst1_result_a", {16'd0, ifa.result}, 32'd0);
        check("rst1_rv_a",     {31'd0, ifa.result_valid}, 32'd0);
        check("rst1_busy_a",   {31'd0, ifa.busy}, 32'd0);
        check("rst1_ovf_a",    {31'd0, ifa.ovf}, 32'd0);
        check("rst1_result_b", {28'd0, ifb.result}, 32'd0);
        check("rst1_ovf_b",    {31'd0, ifb.ovf}, 32'd0);
        wait_cycles(2);
        rst = 1'b0;
        wait_cycles(40);
        check("post_rst_state_a", {30'd0, state_a}, 32'd0);

        check("exp_a_drained",  exp_a_q.size(), 32'd0);
        check("exp_b_drained",  exp_b_q.size(), 32'd0);
        check("busy_a_drained", busy_a_q.size(), 32'd0);
        check("busy_b_drained", busy_b_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end
endmodule
